forward_nn_dense_bram_param: RTL

FORWARD_NN_DENSE_BRAM_PARAM -- requirements
Module: forward_nn_dense_bram_param

---
 rtl/forward_nn_dense_bram_param.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/forward_nn_dense_bram_param.sv
// forward_nn_dense_bram_param
// One dense neural-network layer: y[j] = sat((sum_i x[i]*w[j][i] + (b[j] <<< FRAC)) >>> FRAC).
// The input, weight and result memories are internal. A single MAC unit walks the neurons one at a time.
// Optional build macro FORWARD_NN_DENSE_RELU_EN applies a ReLU after saturation.
// If the macro is left undefined, the saturated value is stored unchanged.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | ready=1, host may write x/w memories, waiting for start
// PREFETCH | first x/w words are read out of memory
// MAC      | acc += x[i]*w[j][i], one input per cycle, N_IN cycles
// BIAS     | acc += b[j] <<< FRAC
// WRITE    | shift, saturate, store y[j], clear acc, next neuron or finish
// DONE     | raises the one-cycle done pulse, then back to IDLE

module forward_nn_dense_bram_param #(
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int N_IN  = 8,
   parameter int N_OUT = 4,
   localparam int XAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int WAW  = (N_OUT * (N_IN + 1) > 1) ? $clog2(N_OUT * (N_IN + 1)) : 1,
   localparam int YAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           clr,
   input  logic           start,
   output logic           ready,
   output logic           done,
   output logic           ovf,
   input  logic           x_ena,
   input  logic           x_wea,
   input  logic [XAW-1:0] x_addra,
   input  logic [DW-1:0]  x_dina,
   input  logic           w_ena,
   input  logic           w_wea,
   input  logic [WAW-1:0] w_addra,
   input  logic [DW-1:0]  w_dina,
   input  logic           y_enb,
   input  logic [YAW-1:0] y_addrb,
   output logic [DW-1:0]  y_doutb
);

   // The N_IN+1 partial sums each fit in 2*DW bits, so this width cannot overflow.
   localparam int AW = 2 * DW + $clog2(N_IN + 1);

   localparam logic [XAW-1:0] I_LAST = XAW'(N_IN - 1);
   localparam logic [YAW-1:0] J_LAST = YAW'(N_OUT - 1);

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_MAC,
      S_BIAS,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [XAW-1:0]        i_q, i_d;
   logic [YAW-1:0]        j_q, j_d;
   logic [WAW-1:0]        wp_q, wp_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;
   logic signed [DW-1:0]  xr_q, xr_d;
   logic signed [DW-1:0]  wr_q, wr_d;
   logic [DW-1:0]         y_dout_q, y_dout_d;

   // Depths are rounded up to a power of two so every address value maps to a real word.
   logic [DW-1:0]         x_mem_q [0:(1 << XAW) - 1];
   logic [DW-1:0]         w_mem_q [0:(1 << WAW) - 1];
   logic [DW-1:0]         y_mem_q [0:(1 << YAW) - 1];

   logic                  x_we;
   logic                  w_we;
   logic                  y_we;
   logic signed [AW-1:0]  mac_term;
   logic signed [AW-1:0]  bias_term;
   logic signed [AW-1:0]  shifted;
   logic [DW-1:0]         res_sat;
   logic [DW-1:0]         res_final;
   logic                  sat;

   assign ready   = (state_q == S_IDLE);
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign y_doutb = y_dout_q;

   // Host writes are only accepted while the engine is idle.
   assign x_we = x_ena & x_wea & ready;
   assign w_we = w_ena & w_wea & ready;

   // Datapath: product, scaled bias, and the shift/saturate/ReLU applied to the finished sum.
   always_comb begin
      mac_term  = AW'(xr_q) * AW'(wr_q);
      bias_term = AW'(wr_q) <<< FRAC;
      shifted   = acc_q >>> FRAC;
      sat       = 1'b0;
      res_sat   = shifted[DW-1:0];
      if (shifted > SAT_MAX) begin
         res_sat = SAT_MAX[DW-1:0];
         sat     = 1'b1;
      end else if (shifted < SAT_MIN) begin
         res_sat = SAT_MIN[DW-1:0];
         sat     = 1'b1;
      end
`ifdef FORWARD_NN_DENSE_RELU_EN
      res_final = res_sat[DW-1] ? '0 : res_sat;
`else
      res_final = res_sat;
`endif
   end

   // Next-state logic: sequencing, counters, accumulator and the sticky overflow flag.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      wp_d    = wp_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      y_we    = 1'b0;
      if (en) begin
         if (clr) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            wp_d    = '0;
            acc_d   = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     state_d = S_PREFETCH;
                     i_d     = '0;
                     j_d     = '0;
                     wp_d    = '0;
                     acc_d   = '0;
                     ovf_d   = 1'b0;
                  end
               end
               S_PREFETCH: begin
                  state_d = S_MAC;
               end
               S_MAC: begin
                  acc_d = acc_q + mac_term;
                  wp_d  = wp_q + 1'b1;
                  if (i_q == I_LAST) begin
                     i_d     = '0;
                     state_d = S_BIAS;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end
               S_BIAS: begin
                  acc_d   = acc_q + bias_term;
                  wp_d    = wp_q + 1'b1;
                  state_d = S_WRITE;
               end
               S_WRITE: begin
                  y_we  = 1'b1;
                  acc_d = '0;
                  if (sat) begin
                     ovf_d = 1'b1;
                  end
                  if (j_q == J_LAST) begin
                     j_d     = '0;
                     wp_d    = '0;
                     state_d = S_DONE;
                  end else begin
                     j_d     = j_q + 1'b1;
                     state_d = S_MAC;
                  end
               end
               S_DONE: begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end
   end

   // Memory read registers load the word needed in the next cycle, using the next-state counters.
   // They hold during a stall, so the operands are still valid when en returns.
   always_comb begin
      xr_d = xr_q;
      wr_d = wr_q;
      if (en) begin
         xr_d = x_mem_q[i_d];
         wr_d = w_mem_q[wp_d];
      end
   end

   // Result read port: one cycle latency, holds while y_enb is low.
   always_comb begin
      y_dout_d = y_dout_q;
      if (y_enb) begin
         y_dout_d = y_mem_q[y_addrb];
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         wp_q     <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         xr_q     <= '0;
         wr_q     <= '0;
         y_dout_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         wp_q     <= wp_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         xr_q     <= xr_d;
         wr_q     <= wr_d;
         y_dout_q <= y_dout_d;
      end
   end

   // Memory arrays have no reset, so their contents survive rst_n.
   always_ff @(posedge clk) begin
      if (x_we) begin
         x_mem_q[x_addra] <= x_dina;
      end
      if (w_we) begin
         w_mem_q[w_addra] <= w_dina;
      end
      if (y_we) begin
         y_mem_q[j_q] <= res_final;
      end
   end

endmodule
